// File: rtl/traffic_pkg.sv
// Shared aspect encodings, monitor state/error types and the phase-to-pattern
// mapping of the two-road traffic-light controller.
package traffic_pkg;

    // Aspect bits are {green, amber, red}.
    localparam logic [2:0] RED       = 3'b001;
    localparam logic [2:0] RED_AMBER = 3'b011;
    localparam logic [2:0] GREEN     = 3'b100;
    localparam logic [2:0] AMBER     = 3'b010;

    typedef enum logic [1:0] {
        UNSYNC,
        SYNCING,
        LOCKED,
        FAULT
    } mon_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_SEQ     = 2'd2,
        ERR_SAFETY  = 2'd3
    } err_code_t;

    // Phases 0..3 cycle road B while A is red; phases 4..7 cycle road A.
    function automatic logic [5:0] phase_pattern(input logic [2:0] p);
        logic [2:0] seq;
        case (p[1:0])
            2'd0:    seq = RED_AMBER;
            2'd1:    seq = GREEN;
            2'd2:    seq = AMBER;
            default: seq = RED;
        endcase
        return p[2] ? {seq, RED} : {RED, seq};
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational decode of an observed {A,B} aspect pair back into a controller
// phase, with legality and safety classification.
module traffic_light_decode
    import traffic_pkg::*;
(
    input  logic [2:0] lightsA,
    input  logic [2:0] lightsB,
    output logic [2:0] phase,
    output logic       valid,
    output logic       ambiguous,
    output logic       illegal,
    output logic       unsafe
);

    always_comb begin
        phase     = 3'd0;
        valid     = 1'b1;
        ambiguous = 1'b0;
        case ({lightsA, lightsB})
            {RED,       RED_AMBER}: phase = 3'd0;
            {RED,       GREEN}:     phase = 3'd1;
            {RED,       AMBER}:     phase = 3'd2;
            {RED_AMBER, RED}:       phase = 3'd4;
            {GREEN,     RED}:       phase = 3'd5;
            {AMBER,     RED}:       phase = 3'd6;
            // All-red occurs at both phase 3 and phase 7, so it cannot seed a lock.
            {RED,       RED}: begin
                valid     = 1'b0;
                ambiguous = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

    assign illegal = ~(valid | ambiguous);
    assign unsafe  = (lightsA[2] | lightsA[1]) & (lightsB[2] | lightsB[1]);

endmodule

// File: rtl/traffic_light_monitor.sv
// Sequence monitor for the traffic-light controller: locks onto the 8-phase
// cycle, faults on deviations, pulses on unsafe aspects and counts full cycles.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int CNT_W       = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             clear,
    input  logic [2:0]       lightsA,
    input  logic [2:0]       lightsB,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       err_code,
    output logic             safety,
    output logic [CNT_W-1:0] cycles
);

    localparam int MATCH_W = $clog2(LOCK_CYCLES + 1);

    logic [2:0] dec_phase;
    logic       dec_valid;
    logic       dec_ambiguous;
    logic       dec_illegal;
    logic       dec_unsafe;

    traffic_light_decode u_decode (
        .lightsA   (lightsA),
        .lightsB   (lightsB),
        .phase     (dec_phase),
        .valid     (dec_valid),
        .ambiguous (dec_ambiguous),
        .illegal   (dec_illegal),
        .unsafe    (dec_unsafe)
    );

    mon_state_t         state, state_n;
    err_code_t          err_q, err_n;
    logic [2:0]         phase_q, phase_n;
    logic [2:0]         expected, expected_n;
    logic [MATCH_W-1:0] match_cnt, match_cnt_n;
    logic [CNT_W-1:0]   cycles_q, cycles_n;
    logic               safety_q, safety_n;

    logic               match;
    logic [MATCH_W-1:0] cnt_inc;

    assign match   = ({lightsA, lightsB} == phase_pattern(expected));
    assign cnt_inc = match_cnt + MATCH_W'(1);

    always_comb begin
        state_n     = state;
        err_n       = err_q;
        phase_n     = phase_q;
        expected_n  = expected;
        match_cnt_n = match_cnt;
        cycles_n    = cycles_q;
        safety_n    = 1'b0;

        if (clear) begin
            state_n     = UNSYNC;
            err_n       = ERR_NONE;
            match_cnt_n = '0;
            safety_n    = sample_en & dec_unsafe;
        end else if (sample_en) begin
            safety_n = dec_unsafe;
            case (state)
                UNSYNC: begin
                    if (dec_valid && !dec_ambiguous) begin
                        phase_n     = dec_phase;
                        expected_n  = dec_phase + 3'd1;
                        match_cnt_n = '0;
                        state_n     = SYNCING;
                    end
                end
                SYNCING: begin
                    if (match) begin
                        phase_n     = expected;
                        expected_n  = expected + 3'd1;
                        match_cnt_n = cnt_inc;
                        if (cnt_inc == MATCH_W'(LOCK_CYCLES)) state_n = LOCKED;
                    end else begin
                        state_n = UNSYNC;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        phase_n    = expected;
                        expected_n = expected + 3'd1;
                        // Accepting phase 0 while locked means a 7->0 wrap.
                        if (expected == 3'd0 && cycles_q != '1)
                            cycles_n = cycles_q + CNT_W'(1);
                    end else begin
                        state_n = FAULT;
                        if (dec_unsafe)       err_n = ERR_SAFETY;
                        else if (dec_illegal) err_n = ERR_ILLEGAL;
                        else                  err_n = ERR_SEQ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= UNSYNC;
            err_q     <= ERR_NONE;
            phase_q   <= 3'd0;
            expected  <= 3'd0;
            match_cnt <= '0;
            cycles_q  <= '0;
            safety_q  <= 1'b0;
        end else begin
            state     <= state_n;
            err_q     <= err_n;
            phase_q   <= phase_n;
            expected  <= expected_n;
            match_cnt <= match_cnt_n;
            cycles_q  <= cycles_n;
            safety_q  <= safety_n;
        end
    end

    assign phase    = phase_q;
    assign locked   = (state == LOCKED);
    assign fault    = (state == FAULT);
    assign err_code = err_q;
    assign safety   = safety_q;
    assign cycles   = cycles_q;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the two-road traffic-light controller. It samples the pair of light outputs, decodes them back into the controller's 8-phase cycle, and locks onto the sequence. Once locked, it flags any deviation from the legal sequence, pulses on unsafe aspect combinations, and counts completed cycles. It sits beside the controller (or on an observed external light bus) as a safety and status monitor.

## Interface
- `LOCK_CYCLES`, default 4: consecutive in-sequence samples required after first recognition before `locked` asserts (≥1).
- `CNT_W`, default 16: width of the completed-cycle counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `sample_en` in 1: sample qualifier; when 0 all state holds.
- `clear` in 1: leave FAULT and return to UNSYNC; also zeroes `fault`/`err_code`.
- `lightsA` in 3: road A aspect, {green, amber, red}.
- `lightsB` in 3: road B aspect, same encoding.
- `phase` out 3: last accepted phase, 0..7.
- `locked` out 1: monitor is in LOCKED.
- `fault` out 1: sticky; monitor is in FAULT.
- `err_code` out 2: 0 none, 1 illegal pattern, 2 sequence mismatch, 3 safety.
- `safety` out 1: single-cycle pulse per unsafe sample (any state).
- `cycles` out CNT_W: completed 7→0 wraps while locked; saturates at all-ones.

## Operation
- Aspect codes: RED 001, RED_AMBER 011, GREEN 100, AMBER 010. Per-road sequence, index 0..3: RED_AMBER, GREEN, AMBER, RED.
- Phase p<4: A=RED, B=seq[p]. Phase p≥4: B=RED, A=seq[p−4]. Phases 3 and 7 are both A=RED, B=RED, so that pattern is ambiguous.
- Decoder: each of the 6 unambiguous legal pairs maps to a unique phase. The pair RED/RED is "ambiguous-legal". Every other pair is illegal.
- Unsafe: (A[2]|A[1]) & (B[2]|B[1]), i.e. both roads show green or amber. Evaluated on every sampled cycle; sets `safety` for that cycle regardless of state.
- States:
  - UNSYNC. An unambiguous legal pattern sets `phase`=p, expected=(p+1) mod 8, and moves to SYNCING with match count 0. Ambiguous, illegal or unsafe patterns: stay, no fault.
  - SYNCING. Sample equal to the pattern for the expected phase: accept, `phase`=expected, expected+1, count+1; when count reaches LOCK_CYCLES, go to LOCKED. Any other sample: return to UNSYNC, no fault.
  - LOCKED. A match is accepted as in SYNCING. A mismatch goes to FAULT with `err_code`=3 if unsafe, else 1 if illegal, else 2; `phase` holds.
  - FAULT. Holds all outputs; ignores samples except for `safety` pulses. `clear` returns to UNSYNC.
- Comparison is against the expected phase's pattern, so RED/RED matches whenever 3 or 7 is expected.
- `cycles` increments when an accepted transition is phase 7→0 in LOCKED. It is never cleared by `clear`; only reset zeroes it.
- Priority: reset > `clear` > `sample_en`. `clear` in a non-FAULT state forces UNSYNC.

## Timing
- All outputs are registered. A sample taken at edge k is reflected in outputs after edge k.
- Reset values: `phase` 0, `locked` 0, `fault` 0, `err_code` 0, `safety` 0, `cycles` 0, state UNSYNC.
- Lock latency: 1 + LOCK_CYCLES sampled edges from the first recognised pattern.
- `sample_en`=0: `safety` goes 0; everything else holds.
- Reset asserted mid-operation restores the reset values at that edge, including `cycles`.
- `clear` and an unsafe sample on the same edge: state goes to UNSYNC, `fault`=0, `safety`=1.
- `cycles` at all-ones stays at all-ones on further wraps.

## Structure
- Package `traffic_pkg`: aspect constants (RED, RED_AMBER, GREEN, AMBER), `mon_state_t` enum (UNSYNC, SYNCING, LOCKED, FAULT), `err_code_t` enum, and a function returning the expected {A,B} pattern for a phase.
- Sub-module `traffic_light_decode` (combinational): inputs lightsA and lightsB; outputs phase, valid, ambiguous, illegal, unsafe.
- Top: FSM, expected-phase register, match counter ($clog2(LOCK_CYCLES+1) bits), cycle counter.

## Test plan
- Reset, then drive the legal sequence from phase 0 with `sample_en`=1 every cycle. `locked`=1 after edge 5 (LOCK_CYCLES=4). `cycles`=1 after edge 9, `phase`=0.
- Locked at phase 1, then drive A=RED, B=RED instead of AMBER. `fault`=1, `err_code`=2, `phase` holds at 1. Pulse `clear`: UNSYNC, `fault`=0, `cycles` unchanged.
- Locked, then drive A=GREEN, B=GREEN. `safety` pulses for 1 cycle, `err_code`=3, `fault`=1. The same input in UNSYNC gives a `safety` pulse only.
- Start sampling on RED/RED: stays UNSYNC until the next RED_AMBER/RED (phase 4) is seen, then SYNCING.
- Toggle `sample_en` 1/0 while locked: phase advances only on enabled edges; no fault from the stalled sequence.
- Drive a long legal run with CNT_W=2: `cycles` saturates at 3. Assert `rst` low mid-run: all outputs 0 after that edge.
